// File: rtl/mux4_sched_pkg.sv
// Shared definitions for the 4:1 mux round-robin scheduler.
//   state_e       : scheduler FSM states (2-bit encoding)
//   IDX_A..IDX_D  : mux input indices, which are also requester indices
//   onehot4()     : index to one-hot grant vector
package mux4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_e;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requesters.
// Searches ptr, ptr+1, ... (mod 4) and returns the first index whose
// request and mask bits are both set.
//   req  in  4  request vector
//   mask in  4  eligibility mask
//   ptr  in  2  highest-priority index
//   idx  out 2  chosen index (0 when nothing is eligible)
//   any  out 1  at least one eligible requester
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    always_comb begin
        idx  = 2'd0;
        any  = 1'b0;
        cand = 2'd0;
        for (int i = 0; i < 4; i++) begin
            // 2-bit addition wraps naturally past index 3.
            cand = ptr + 2'(i);
            if (!any && req[cand] && mask[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 transmission-gate mux among four
// requesters (mux inputs A,B,C,D = requesters 0..3). It drives the mux select,
// waits for the mux to settle after every select change, then issues a one-hot
// grant with a valid strobe. A holder is preempted after MAX_HOLD grant cycles
// if someone else is waiting.
//   clk       in  1  clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   req       in  4  request per mux input
//   sel       out 2  mux select {S1,S0}
//   gnt       out 4  one-hot grant, aligned with sel
//   out_valid out 1  mux output settled and owned by the granted requester
module mux4_rr_sched #(
    parameter int unsigned SETTLE_CYC = 2,   // 1..15
    parameter int unsigned MAX_HOLD   = 16   // 2..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       out_valid
);

    import mux4_sched_pkg::*;

    // Settle load when leaving IDLE or re-picking after a withdrawn request.
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYC - 1);
    // Handover from a grant adds one dead cycle ahead of the settle window.
    localparam logic [3:0] SettleHandover = 4'(SETTLE_CYC);
    localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] hold_q, hold_d;

    logic [3:0] pick_mask;
    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       others;

    // One picker serves every state: from IDLE the search starts at ptr; after
    // a grant or a withdrawal it starts just past the current select, and a
    // departing holder is masked out so it cannot win its own handover.
    always_comb begin
        pick_ptr  = (state_q == IDLE) ? ptr_q : sel_q + 2'd1;
        pick_mask = (state_q == GRANT) ? ~onehot4(sel_q) : 4'hf;
    end

    rr_pick4 u_pick (
        .req  (req),
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign others = |(req & ~onehot4(sel_q));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        settle_d = settle_q;
        hold_d   = hold_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d    = pick_idx;
                    settle_d = SettleLoad;
                    state_d  = SETTLE;
                end
            end

            SETTLE: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else if (req[sel_q]) begin
                    gnt_d   = onehot4(sel_q);
                    valid_d = 1'b1;
                    hold_d  = 8'd0;
                    state_d = GRANT;
                end else begin
                    // Request withdrawn before the grant: skip it, no pulse.
                    ptr_d = sel_q + 2'd1;
                    if (pick_any) begin
                        sel_d    = pick_idx;
                        settle_d = SettleLoad;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GRANT: begin
                // Release wins over preempt; both take the same path.
                if (!req[sel_q] || (hold_q == HoldMax && others)) begin
                    gnt_d   = 4'd0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    if (pick_any) begin
                        sel_d    = pick_idx;
                        settle_d = SettleHandover;
                        state_d  = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= IDX_A;
            gnt_q    <= 4'd0;
            valid_q  <= 1'b0;
            ptr_q    <= IDX_A;
            settle_q <= 4'd0;
            hold_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched: a per-cycle vector table, directed
// multi-cycle sequences, and random requests checked against a reference model.
module tb_mux4_rr_sched;

    localparam int unsigned SC = 2;
    localparam int unsigned MH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'd0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       out_valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(
        .SETTLE_CYC (SC),
        .MAX_HOLD   (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- per-cycle invariants ----------------
    logic [1:0] prev_sel = 2'd0;
    logic       inv_en = 1'b0;

    always @(negedge clk) begin
        if (inv_en && rst_n) begin
            check("inv_onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
            check("inv_valid_eq_or_gnt", 32'(out_valid), 32'(|gnt));
            if (gnt != 4'd0) check("inv_sel_stable", 32'(sel), 32'(prev_sel));
        end
        prev_sel <= sel;
    end

    // ---------------- reference model ----------------
    int m_ptr, m_owner, m_tgt, m_wait, m_held, m_sel;

    function automatic int pick_from(input int start, input logic [3:0] r, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_tgt = -1; m_wait = 0; m_held = 0; m_sel = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int nxt;
        bit oth;
        if (m_owner >= 0) begin
            oth = 0;
            for (int i = 0; i < 4; i++) if (i != m_owner && r[i]) oth = 1;
            if (!r[m_owner] || (m_held == int'(MH) - 1 && oth)) begin
                m_ptr = (m_owner + 1) % 4;
                nxt = pick_from(m_ptr, r, m_owner);
                m_owner = -1;
                if (nxt >= 0) begin
                    m_tgt = nxt; m_sel = nxt; m_wait = int'(SC);
                end else begin
                    m_tgt = -1;
                end
            end else if (m_held < int'(MH) - 1) begin
                m_held++;
            end
        end else if (m_tgt >= 0) begin
            if (m_wait > 0) begin
                m_wait--;
            end else if (r[m_tgt]) begin
                m_owner = m_tgt; m_held = 0; m_tgt = -1;
            end else begin
                m_ptr = (m_tgt + 1) % 4;
                nxt = pick_from(m_ptr, r, -1);
                if (nxt >= 0) begin
                    m_tgt = nxt; m_sel = nxt; m_wait = int'(SC) - 1;
                end else begin
                    m_tgt = -1;
                end
            end
        end else begin
            nxt = pick_from(m_ptr, r, -1);
            if (nxt >= 0) begin
                m_tgt = nxt; m_sel = nxt; m_wait = int'(SC) - 1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) at falling edges until gnt equals exp; returns cycles taken.
    task automatic wait_for_gnt(input logic [3:0] exp, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (gnt !== exp && cycles < budget);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       vld;
    } vec_t;

    vec_t tbl[37];

    function automatic vec_t v(input logic [3:0] r, input logic [1:0] s,
                               input logic [3:0] g, input logic vl);
        vec_t x;
        x.req = r; x.sel = s; x.gnt = g; x.vld = vl;
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c, n, z;
        bit ok;
        logic [3:0] eg;

        // req applied before the edge, expected outputs after it.
        tbl[0]  = v(4'b0000, 2'd0, 4'b0000, 0);
        tbl[1]  = v(4'b0100, 2'd2, 4'b0000, 0);
        tbl[2]  = v(4'b0100, 2'd2, 4'b0000, 0);
        tbl[3]  = v(4'b0100, 2'd2, 4'b0100, 1);
        tbl[4]  = v(4'b0100, 2'd2, 4'b0100, 1);
        tbl[5]  = v(4'b0000, 2'd2, 4'b0000, 0);
        tbl[6]  = v(4'b0000, 2'd2, 4'b0000, 0);
        tbl[7]  = v(4'b1001, 2'd3, 4'b0000, 0);
        tbl[8]  = v(4'b0001, 2'd3, 4'b0000, 0);
        tbl[9]  = v(4'b0001, 2'd0, 4'b0000, 0);
        tbl[10] = v(4'b0001, 2'd0, 4'b0000, 0);
        tbl[11] = v(4'b0001, 2'd0, 4'b0001, 1);
        tbl[12] = v(4'b0000, 2'd0, 4'b0000, 0);
        tbl[13] = v(4'b1111, 2'd1, 4'b0000, 0);
        tbl[14] = v(4'b1111, 2'd1, 4'b0000, 0);
        tbl[15] = v(4'b1111, 2'd1, 4'b0010, 1);
        tbl[16] = v(4'b1101, 2'd2, 4'b0000, 0);
        tbl[17] = v(4'b1101, 2'd2, 4'b0000, 0);
        tbl[18] = v(4'b1101, 2'd2, 4'b0000, 0);
        tbl[19] = v(4'b1101, 2'd2, 4'b0100, 1);
        tbl[20] = v(4'b0000, 2'd2, 4'b0000, 0);
        tbl[21] = v(4'b0000, 2'd2, 4'b0000, 0);
        tbl[22] = v(4'b0001, 2'd0, 4'b0000, 0);
        tbl[23] = v(4'b0000, 2'd0, 4'b0000, 0);
        tbl[24] = v(4'b0000, 2'd0, 4'b0000, 0);
        tbl[25] = v(4'b0011, 2'd1, 4'b0000, 0);
        tbl[26] = v(4'b0011, 2'd1, 4'b0000, 0);
        tbl[27] = v(4'b0011, 2'd1, 4'b0010, 1);
        tbl[28] = v(4'b0000, 2'd1, 4'b0000, 0);
        tbl[29] = v(4'b1001, 2'd3, 4'b0000, 0);
        tbl[30] = v(4'b1001, 2'd3, 4'b0000, 0);
        tbl[31] = v(4'b1001, 2'd3, 4'b1000, 1);
        tbl[32] = v(4'b0001, 2'd0, 4'b0000, 0);
        tbl[33] = v(4'b0001, 2'd0, 4'b0000, 0);
        tbl[34] = v(4'b0001, 2'd0, 4'b0000, 0);
        tbl[35] = v(4'b0001, 2'd0, 4'b0001, 1);
        tbl[36] = v(4'b0000, 2'd0, 4'b0000, 0);

        // Reset state, observed while reset is still asserted.
        rst_n = 1'b0;
        #12;
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        do_reset();
        inv_en = 1'b1;

        // Vector table.
        for (int i = 0; i < 37; i++) begin
            req = tbl[i].req;
            @(negedge clk);
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
        end

        // Round-robin order with req=1111, each holder drops 3 cycles in.
        do_reset();
        req = 4'b1111;
        wait_for_gnt(4'b0001, 10, c);
        check("rr_first_latency", 32'(c), 32'(SC + 1));
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = k % 4;
            check($sformatf("rr_order%0d", k), 32'(gnt), 32'(4'b0001 << idx));
            repeat (2) @(negedge clk);
            req[idx] = 1'b0;
            @(negedge clk);
            z = (gnt == 4'd0) ? 1 : 0;
            req[idx] = 1'b1;
            while (z > 0 && z < 20) begin
                @(negedge clk);
                if (gnt == 4'd0) z++;
                else break;
            end
            check($sformatf("rr_dead%0d", k), 32'(z), 32'(SC + 1));
        end

        // Preempt with req=0011 held.
        do_reset();
        req = 4'b0011;
        wait_for_gnt(4'b0001, 10, c);
        check("preempt_first_gnt", 32'(gnt), 32'b0001);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (gnt == 4'b0001) n++;
            else break;
        end
        check("preempt_hold_len", 32'(n), 32'(MH));
        z = (gnt == 4'd0) ? 1 : 0;
        while (z > 0 && z < 20) begin
            @(negedge clk);
            if (gnt == 4'd0) z++;
            else break;
        end
        check("preempt_dead", 32'(z), 32'(SC + 1));
        check("preempt_next_gnt", 32'(gnt), 32'b0010);

        // Lone requester holds indefinitely, then yields to a newcomer.
        do_reset();
        req = 4'b1000;
        wait_for_gnt(4'b1000, 10, c);
        ok = 1;
        repeat (100) begin
            @(negedge clk);
            if (gnt !== 4'b1000 || out_valid !== 1'b1) ok = 0;
        end
        check("alone_hold_100", 32'(ok), 32'd1);
        req = 4'b1010;
        wait_for_gnt(4'b0010, 30, c);
        check("alone_yield_gnt", 32'(gnt), 32'b0010);
        check("alone_yield_latency", 32'(c), 32'(SC + 2));

        // Asynchronous reset mid-grant, then normal latency afterwards.
        do_reset();
        req = 4'b0100;
        wait_for_gnt(4'b0100, 10, c);
        check("areset_pre_latency", 32'(c), 32'(SC + 1));
        check("areset_pre_sel", 32'(sel), 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_gnt", 32'(gnt), 32'd0);
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0001;
        wait_for_gnt(4'b0001, 10, c);
        check("areset_post_gnt", 32'(gnt), 32'b0001);
        check("areset_post_latency", 32'(c), 32'(SC + 1));

        // Random requests against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            @(posedge clk);
            model_step(req);
            @(negedge clk);
            eg = 4'd0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            check("rand_sel", 32'(sel), 32'(m_sel));
            check("rand_gnt", 32'(gnt), 32'(eg));
            check("rand_valid", 32'(out_valid), 32'(m_owner >= 0));
        end

        inv_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
